// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO register owner with a 32-iteration shift-add multiplier serving
// MULT/MADD/MSUB (signed and unsigned) plus MTHI/MTLO.
module hilo_muldiv_sequencer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] partial;
    logic [4:0]  count;
    logic        neg;
    logic [2:0]  op_held;
    logic        busy_flag;
    logic        done_flag;

    logic        accept;
    logic        mt_write;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] product;
    logic [63:0] acc;
    logic [63:0] result;

    // Next-state and issue decode; Start only matters in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mt_write   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Op[2:1] != 2'b11) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        mt_write = 1'b1;
                    end
                end
            end
            RUN: begin
                if (count == 5'd31) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand magnitudes (signed ops) and the final sign-corrected result.
    always_comb begin
        mag_a   = (!Op[0] && A[31]) ? (~A + 32'd1) : A;
        mag_b   = (!Op[0] && B[31]) ? (~B + 32'd1) : B;
        product = neg ? (~partial + 64'd1) : partial;
        acc     = {Hi, Lo};
        case (op_held[2:1])
            2'b01:   result = acc + product;
            2'b10:   result = acc - product;
            default: result = product;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Busy/Done are registered copies of the upcoming state so no input
    // reaches an output combinationally.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            busy_flag <= (state_next != IDLE);
            done_flag <= (state == FINISH);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            count   <= '0;
            neg     <= 1'b0;
            op_held <= '0;
            Hi      <= '0;
            Lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand   <= {32'd0, mag_a};
                        mplier  <= mag_b;
                        neg     <= !Op[0] && (A[31] ^ B[31]);
                        op_held <= Op;
                        partial <= '0;
                        count   <= '0;
                    end else if (mt_write) begin
                        if (Op[0]) begin
                            Lo <= A;
                        end else begin
                            Hi <= A;
                        end
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        partial <= partial + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                end
                FINISH: begin
                    {Hi, Lo} <= result;
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy  = busy_flag;
    assign Stall = busy_flag;
    assign Done  = done_flag;

endmodule

// File: doc/hilo_muldiv_sequencer.md
# hilo_muldiv_sequencer

Multi-cycle multiply/accumulate unit and HI/LO register owner for the MIPS datapath, serving the SPECIAL2 multiply group (opcode 011100) plus MTHI/MTLO. The datapath controller issues one operation with two register operands. The block runs a 32-iteration shift-add multiply, applies sign correction and accumulation, and writes HI/LO. It asserts Stall for the whole run so the pipeline freezes until the result is architecturally visible.

## Interface
Parameters:
- none; the datapath width is fixed at 32 bits and the product width at 64 bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  reset. Synchronous and active-low.
- Start  in  1  issue strobe. Sampled only while the FSM is in IDLE.
- Op  in  3  operation code:
  - 000 MULT, 001 MULTU
  - 010 MADD, 011 MADDU
  - 100 MSUB, 101 MSUBU
  - 110 MTHI, 111 MTLO
- A  in  32  rs operand; also the source for MTHI/MTLO.
- B  in  32  rt operand.
- Busy  out  1  high while the FSM is not in IDLE.
- Stall  out  1  pipeline freeze request; identical to Busy.
- Done  out  1  one-cycle pulse: multiply-class result now visible on Hi/Lo.
- Hi  out  32  HI register.
- Lo  out  32  LO register.

## Operation
States:
- **IDLE**
  - Start=1 with Op[2:1]!=11: capture A, B, Op and the signedness flag (Op[0]=0 means signed).
    - Store magnitudes |A|, |B| for signed ops, raw A, B for unsigned ops.
    - Record the product sign as A[31]^B[31] for signed ops, 0 otherwise.
    - Clear the 64-bit partial product and the 5-bit counter; go to RUN.
  - Start=1 with Op=110 or 111: write A to HI or LO respectively at that edge and stay in IDLE. No Busy, no Done.
  - Start=0: hold.
- **RUN**
  - Each cycle: if multiplier bit 0 is 1, add the shifted multiplicand to the partial product.
  - Then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
  - When the counter reaches 31 (the 32nd RUN cycle), go to FINISH.
- **FINISH**
  - P = product sign ? (~partial + 1) : partial, all 64 bits.
  - Write {Hi,Lo} at this edge:
    - MULT/MULTU: P.
    - MADD/MADDU: {Hi,Lo} + P.
    - MSUB/MSUBU: {Hi,Lo} − P.
  - All arithmetic is modulo 2^64 with no overflow detection.
  - Go to IDLE and set Done for the next cycle.

Rules:
- Operands are captured at Start. Changes to A, B or Op during Busy have no effect.
- Start while Busy is ignored; the request is not queued. The controller must hold the instruction while Stall=1.
- Hi/Lo keep their old values throughout RUN and FINISH and change only at the FINISH edge.
- Done is registered and high only in the first IDLE cycle after FINISH.
  - A Start in that same cycle is accepted normally.
  - Done still deasserts after one cycle.
- Rst=0 at any edge, including mid-RUN:
  - FSM goes to IDLE, and the counter and partial product clear.
  - Hi=0, Lo=0, Busy=0, Stall=0, Done=0.
  - The operation in flight is discarded and never writes Hi/Lo.

## Timing
- Reset values: Hi=0, Lo=0, Busy=0, Stall=0, Done=0, FSM=IDLE.
- Multiply-class latency, with Start sampled at edge 0:
  - Busy/Stall are high for cycles 1–33 (32 RUN + 1 FINISH).
  - The new Hi/Lo and Done=1 appear in cycle 34.
  - Back-to-back issue rate is one operation per 34 cycles.
- MTHI/MTLO latency: Hi or Lo updates at edge 0 and is visible in cycle 1.
- Busy, Stall, Done, Hi and Lo are all driven directly from registers, with no combinational path from inputs.

## Test plan
- **Reset:** assert Rst=0 for 2 cycles, then release → Hi=Lo=0, Busy=Done=0.
- **MULT signed:** A=0xFFFFFFFF, B=0x00000002, Op=000 → Busy for cycles 1–33; cycle 34 shows Done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
- **MULTU, same operands:** Op=001 → Hi=0x00000001, Lo=0xFFFFFFFE after 34 cycles.
- **MTLO then MADD:** MTLO A=0x10; MTHI A=0; then MADD A=3, B=4 → Lo=0x1C, Hi=0. A second Start issued in the Done cycle is accepted.
- **MSUBU underflow:** Hi=Lo=0, A=1, B=1, Op=101 → Hi=Lo=0xFFFFFFFF.
- **Disturbance and abort:**
  - Start pulses while Busy, and A/B toggled mid-RUN → ignored; result matches the captured operands.
  - Rst=0 at RUN cycle 10 → next cycle shows Busy=0, Hi=Lo=0, and Done never pulses.
